cordic_rr_sched: RTL and testbench

//  Round-robin scheduler sharing one 12-stage pipelined CORDIC sin/cos engine between NREQ phase requesters.

---
 rtl/cordic_rr_sched.sv | 144 ++++++++++++++
 tb/tb_cordic_rr_sched.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rr_sched.sv
// Round-robin front end sharing one pipelined CORDIC sin/cos engine between NREQ phase requesters.
// Define CORDIC_SCHED_FIXPRIO_EN for fixed lowest-index-wins priority; DBG_STATE: 0 IDLE, 1 RUN, 2 DRAIN.
module cordic_rr_sched #(
    parameter int NREQ = 4,
    parameter int LAT  = 13,
    parameter int TAGW = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    output logic                BUSY,
    input  logic [NREQ-1:0]     REQ_VALID,
    input  logic [NREQ*32-1:0]  REQ_PHASE,
    output logic [NREQ-1:0]     REQ_READY,
    output logic [31:0]         C_PHASE,
    input  logic [31:0]         C_SIN,
    input  logic [31:0]         C_COS,
    input  logic [31:0]         C_ERR,
    output logic [NREQ-1:0]     RES_VALID,
    output logic [31:0]         RES_SIN,
    output logic [31:0]         RES_COS,
    output logic [31:0]         RES_ERR,
    output logic [1:0]          DBG_STATE
);
    localparam int CNTW = $clog2(LAT + 2);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [TAGW-1:0] start_idx, cand, grant_idx;
    logic            hs;
    logic [31:0]     phase_sel;
    logic [LAT:0]    tag_vld_q, tag_vld_d;
    logic [TAGW-1:0] tag_idx_q [LAT+1];
    logic [TAGW-1:0] tag_idx_d [LAT+1];
    logic [CNTW-1:0] inflight_q, inflight_d;
    logic [31:0]     c_phase_q, c_phase_d;
    logic [NREQ-1:0] res_valid_q, res_valid_d;
    logic [31:0]     res_sin_q, res_sin_d, res_cos_q, res_cos_d, res_err_q, res_err_d;

`ifdef CORDIC_SCHED_FIXPRIO_EN
    assign start_idx = '0;
`else
    logic [TAGW-1:0] ptr_q, ptr_d;

    assign start_idx = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (hs) ptr_d = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + TAGW'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`endif

    // Handshake: REQ_VALID[i] & REQ_READY[i]; grants only in RUN, first valid at or after start_idx.
    always_comb begin
        REQ_READY = '0;
        hs        = 1'b0;
        cand      = '0;
        grant_idx = '0;
        phase_sel = '0;
        if (state_q == RUN) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = TAGW'((int'(start_idx) + k) % NREQ);
                if (!hs && REQ_VALID[cand]) begin
                    hs        = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (hs && int'(grant_idx) == k) begin
                REQ_READY[k] = 1'b1;
                phase_sel    = REQ_PHASE[32*k +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (EN) state_d = RUN;
            RUN:     if (!EN) state_d = (inflight_q != '0) ? DRAIN : IDLE;
            DRAIN:   if (EN) state_d = RUN;
                     else if (inflight_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Tag stage k lines up with the engine output LAT cycles after C_PHASE changed.
        tag_vld_d    = {tag_vld_q[LAT-1:0], hs};
        tag_idx_d[0] = grant_idx;
        for (int k = 1; k <= LAT; k++) tag_idx_d[k] = tag_idx_q[k-1];

        inflight_d = inflight_q + CNTW'(hs) - CNTW'(tag_vld_q[LAT]);
        c_phase_d  = hs ? phase_sel : c_phase_q;

        res_valid_d = '0;
        res_sin_d   = res_sin_q;
        res_cos_d   = res_cos_q;
        res_err_d   = res_err_q;
        if (tag_vld_q[LAT]) begin
            res_valid_d[tag_idx_q[LAT]] = 1'b1;
            res_sin_d = C_SIN;
            res_cos_d = C_COS;
            res_err_d = C_ERR;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            tag_vld_q   <= '0;
            tag_idx_q   <= '{default: '0};
            inflight_q  <= '0;
            c_phase_q   <= '0;
            res_valid_q <= '0;
            res_sin_q   <= '0;
            res_cos_q   <= '0;
            res_err_q   <= '0;
        end else begin
            state_q     <= state_d;
            tag_vld_q   <= tag_vld_d;
            tag_idx_q   <= tag_idx_d;
            inflight_q  <= inflight_d;
            c_phase_q   <= c_phase_d;
            res_valid_q <= res_valid_d;
            res_sin_q   <= res_sin_d;
            res_cos_q   <= res_cos_d;
            res_err_q   <= res_err_d;
        end
    end

    assign BUSY      = (state_q != IDLE) | (inflight_q != '0);
    assign C_PHASE   = c_phase_q;
    assign RES_VALID = res_valid_q;
    assign RES_SIN   = res_sin_q;
    assign RES_COS   = res_cos_q;
    assign RES_ERR   = res_err_q;
    assign DBG_STATE = state_q;
endmodule

// File: tb/tb_cordic_rr_sched.sv
// Bench for cordic_rr_sched: a stub engine with a 13-cycle phase-to-result delay, a queue-based
// reference scoreboard checked every cycle, and directed plus random scenario tasks.
module tb_cordic_rr_sched;
    localparam int NREQ = 4;
    localparam int LAT  = 13;
    localparam int W    = 55;   // {due[19:0], owner[2:0], phase[31:0]}

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         EN = 1'b0;
    logic         BUSY;
    logic [3:0]   REQ_VALID = '0;
    logic [127:0] REQ_PHASE = '0;
    logic [3:0]   REQ_READY, RES_VALID;
    logic [31:0]  C_PHASE, C_SIN, C_COS, C_ERR, RES_SIN, RES_COS, RES_ERR;
    logic [1:0]   DBG_STATE;

    int n_checks = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    cordic_rr_sched #(.NREQ(NREQ), .LAT(LAT), .TAGW(2)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .BUSY(BUSY),
        .REQ_VALID(REQ_VALID), .REQ_PHASE(REQ_PHASE), .REQ_READY(REQ_READY),
        .C_PHASE(C_PHASE), .C_SIN(C_SIN), .C_COS(C_COS), .C_ERR(C_ERR),
        .RES_VALID(RES_VALID), .RES_SIN(RES_SIN), .RES_COS(RES_COS), .RES_ERR(RES_ERR),
        .DBG_STATE(DBG_STATE)
    );

    function automatic logic [31:0] f_sin(input logic [31:0] p);
        return {p[15:0], p[31:16]} ^ 32'h0000_0622;
    endfunction
    function automatic logic [31:0] f_cos(input logic [31:0] p);
        return p ^ 32'h0622_0000;
    endfunction
    function automatic logic [31:0] f_err(input logic [31:0] p);
        return p + 32'h0000_1357;
    endfunction

    // Stub engine: the result for a phase appears 13 cycles after it shows up on C_PHASE.
    logic [31:0] eng [0:LAT-1];
    always @(posedge CLK) begin
        eng[0] <= C_PHASE;
        for (int k = 1; k < LAT; k++) eng[k] <= eng[k-1];
    end
    assign C_SIN = f_sin(eng[LAT-1]);
    assign C_COS = f_cos(eng[LAT-1]);
    assign C_ERR = f_err(eng[LAT-1]);

    // Reference model state (0 idle, 1 run, 2 drain) and expected queue of in-flight samples.
    logic [W-1:0] exp_q[$];
    int          m_state = 0, m_ptr = 0, cyc = 0, s_owner = 0, s_infl = 0;
    bit          s_rst = 1'b0, s_hs = 1'b0, s_en = 1'b0;
    logic [31:0] s_phase = '0;
    logic [3:0]  m_rv = '0, exp_rdy;
    logic [31:0] m_sin = '0, m_cos = '0, m_err = '0, m_cphase = '0;

    task automatic scoreboard_loop();
        logic [W-1:0] e;
        forever begin
            @(negedge CLK);
            if (RST) begin
                m_state = 0; m_ptr = 0; exp_q.delete(); m_rv = '0;
                m_sin = '0; m_cos = '0; m_err = '0; m_cphase = '0; s_rst = 1'b1;
            end else if (s_rst) begin
                s_rst = 1'b0;
            end else begin
                cyc++;
                m_rv = '0;
                if (exp_q.size() > 0 && int'(exp_q[0][54:35]) == cyc) begin
                    e = exp_q.pop_front();
                    m_rv = 4'b0001 << e[34:32];
                    m_sin = f_sin(e[31:0]); m_cos = f_cos(e[31:0]); m_err = f_err(e[31:0]);
                end
                case (m_state)
                    0: if (s_en) m_state = 1;
                    1: if (!s_en) m_state = (s_infl != 0) ? 2 : 0;
                    default: if (s_en) m_state = 1; else if (s_infl == 0) m_state = 0;
                endcase
                if (s_hs) begin
                    exp_q.push_back({20'(cyc + LAT + 1), 3'(s_owner), s_phase});
                    m_cphase = s_phase;
`ifndef CORDIC_SCHED_FIXPRIO_EN
                    m_ptr = (s_owner + 1) % NREQ;
`endif
                end
            end
            n_checks += 7;
            if (RES_VALID !== m_rv) begin n_fail++; $display("FAIL res_valid cyc %0d: got %b expected %b", cyc, RES_VALID, m_rv); end
            if (RES_SIN !== m_sin) begin n_fail++; $display("FAIL res_sin cyc %0d: got %h expected %h", cyc, RES_SIN, m_sin); end
            if (RES_COS !== m_cos) begin n_fail++; $display("FAIL res_cos cyc %0d: got %h expected %h", cyc, RES_COS, m_cos); end
            if (RES_ERR !== m_err) begin n_fail++; $display("FAIL res_err cyc %0d: got %h expected %h", cyc, RES_ERR, m_err); end
            if (C_PHASE !== m_cphase) begin n_fail++; $display("FAIL c_phase cyc %0d: got %h expected %h", cyc, C_PHASE, m_cphase); end
            if (DBG_STATE !== 2'(m_state)) begin n_fail++; $display("FAIL state cyc %0d: got %0d expected %0d", cyc, DBG_STATE, m_state); end
            if (BUSY !== ((m_state != 0) || (exp_q.size() != 0))) begin
                n_fail++; $display("FAIL busy cyc %0d: got %b expected %b", cyc, BUSY, (m_state != 0) || (exp_q.size() != 0));
            end
            exp_rdy = '0; s_hs = 1'b0; s_owner = 0;
            if (!RST && m_state == 1) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (!s_hs && REQ_VALID[(m_ptr + k) % NREQ]) begin
                        s_hs = 1'b1; s_owner = (m_ptr + k) % NREQ; exp_rdy[s_owner] = 1'b1;
                    end
                end
            end
            n_checks++;
            if (REQ_READY !== exp_rdy) begin n_fail++; $display("FAIL req_ready cyc %0d: got %b expected %b", cyc, REQ_READY, exp_rdy); end
            s_phase = REQ_PHASE[32*s_owner +: 32];
            s_en    = EN;
            s_infl  = exp_q.size();
        end
    endtask

    task automatic apply_reset();
        @(posedge CLK); #1;
        RST = 1'b1; EN = 1'b0; REQ_VALID = '0;
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic start_run();
        apply_reset();
        EN = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        @(negedge CLK); @(negedge CLK);
        n_checks += 4;
        if (REQ_READY !== 4'b0 || RES_VALID !== 4'b0) begin n_fail++; $display("FAIL reset_strobes: got %b/%b expected 0/0", REQ_READY, RES_VALID); end
        if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        if (C_PHASE !== 32'h0 || RES_SIN !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h/%h expected 0/0", C_PHASE, RES_SIN); end
        if (RES_COS !== 32'h0 || RES_ERR !== 32'h0 || DBG_STATE !== 2'd0) begin
            n_fail++; $display("FAIL reset_misc: got %h/%h/%0d expected 0/0/0", RES_COS, RES_ERR, DBG_STATE);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic test_single();
        int lat = -1;
        logic [3:0] got = '0;
        logic busy_at = 1'b0, busy_after = 1'b1;
        start_run();
        REQ_VALID = 4'b0001; REQ_PHASE = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge CLK); #1;
            if (k == 1) begin REQ_VALID = '0; EN = 1'b0; end
            if (lat < 0 && RES_VALID != 4'b0) begin lat = k - 1; got = RES_VALID; busy_at = BUSY; end
            if (lat >= 0 && k == lat + 2) busy_after = BUSY;
        end
        n_checks += 4;
        if (lat != LAT + 1) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", lat, LAT + 1); end
        if (got !== 4'b0001) begin n_fail++; $display("FAIL single_owner: got %b expected 0001", got); end
        if (busy_at !== 1'b1) begin n_fail++; $display("FAIL single_busy_at_result: got %b expected 1", busy_at); end
        if (busy_after !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b expected 0", busy_after); end
    endtask

    task automatic test_rr_burst();
        logic [3:0] seq [8];
        int n = 0, first = -1, last = -1;
        start_run();
        REQ_VALID = 4'hF;
        REQ_PHASE = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            n_checks++;
            if (REQ_READY !== (4'b0001 << (k % 4))) begin n_fail++; $display("FAIL burst_grant %0d: got %b expected %b", k, REQ_READY, 4'b0001 << (k % 4)); end
            @(posedge CLK); #1;
            REQ_PHASE = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        REQ_VALID = '0;
        for (int k = 0; k < 30; k++) begin
            @(posedge CLK); #1;
            if (RES_VALID != 4'b0) begin
                if (n < 8) seq[n] = RES_VALID;
                if (first < 0) first = k;
                last = k; n++;
            end
        end
        n_checks += 2;
        if (n != 8 || last - first != 7) begin n_fail++; $display("FAIL burst_results: got %0d over %0d cycles expected 8 over 8", n, last - first + 1); end
        for (int k = 0; k < 8 && k < n; k++) begin
            if (seq[k] !== (4'b0001 << (k % 4))) begin n_fail++; $display("FAIL burst_order %0d: got %b expected %b", k, seq[k], 4'b0001 << (k % 4)); end
        end
        EN = 1'b0;
    endtask

    task automatic test_quadrant();
        logic [3:0] got = '0;
        logic [31:0] sin_got = '0;
        start_run();
        REQ_VALID = 4'b0100; REQ_PHASE = '0; REQ_PHASE[95:64] = 32'h0001_0000;
        for (int k = 1; k <= 20; k++) begin
            @(posedge CLK); #1;
            if (k == 1) REQ_VALID = '0;
            if (got == 4'b0 && RES_VALID != 4'b0) begin got = RES_VALID; sin_got = RES_SIN; end
        end
        n_checks += 2;
        if (got !== 4'b0100) begin n_fail++; $display("FAIL quad_owner: got %b expected 0100", got); end
        if (sin_got !== f_sin(32'h0001_0000)) begin n_fail++; $display("FAIL quad_sin: got %h expected %h", sin_got, f_sin(32'h0001_0000)); end
        EN = 1'b0;
    endtask

    task automatic test_drain();
        int n = 0;
        logic [3:0] rdy_seen = '0, granted = '0;
        start_run();
        for (int s = 0; s < 5; s++) begin
            REQ_VALID = 4'b0001 << $urandom_range(0, 3);
            REQ_PHASE = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge CLK); #1;
        end
        EN = 1'b0; REQ_VALID = '0;
        @(posedge CLK); #1;
        n_checks++;
        if (DBG_STATE !== 2'd2) begin n_fail++; $display("FAIL drain_state: got %0d expected 2", DBG_STATE); end
        REQ_VALID = 4'b0110;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            rdy_seen |= REQ_READY;
            @(posedge CLK); #1;
            if (RES_VALID != 4'b0) n++;
            if (BUSY == 1'b0) break;
        end
        n_checks += 3;
        if (n != 5) begin n_fail++; $display("FAIL drain_count: got %0d expected 5", n); end
        if (rdy_seen !== 4'b0) begin n_fail++; $display("FAIL drain_ready: got %b expected 0000", rdy_seen); end
        if (BUSY !== 1'b0 || DBG_STATE !== 2'd0) begin n_fail++; $display("FAIL drain_idle: got %b/%0d expected 0/0", BUSY, DBG_STATE); end
        EN = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            granted |= REQ_READY;
            @(posedge CLK); #1;
            REQ_VALID &= ~granted;
        end
        n_checks++;
        if (granted !== 4'b0110) begin n_fail++; $display("FAIL drain_held_granted: got %b expected 0110", granted); end
        EN = 1'b0;
        repeat (20) @(posedge CLK);
        #1;
    endtask

    task automatic test_rst_mid();
        int n = 0;
        start_run();
        REQ_VALID = 4'hF;
        REQ_PHASE = {$urandom(), $urandom(), $urandom(), $urandom()};
        repeat (3) begin @(posedge CLK); #1; end
        REQ_VALID = '0; EN = 1'b0;
        repeat (5) @(posedge CLK);
        #1 RST = 1'b1;
        @(negedge CLK);
        n_checks += 2;
        if (BUSY !== 1'b0 || RES_VALID !== 4'b0) begin n_fail++; $display("FAIL rst_mid_clear: got %b/%b expected 0/0000", BUSY, RES_VALID); end
        if (C_PHASE !== 32'h0 || RES_SIN !== 32'h0) begin n_fail++; $display("FAIL rst_mid_data: got %h/%h expected 0/0", C_PHASE, RES_SIN); end
        @(posedge CLK); #1 RST = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(posedge CLK); #1;
            if (RES_VALID != 4'b0) n++;
        end
        n_checks++;
        if (n != 0) begin n_fail++; $display("FAIL rst_mid_discard: got %0d results expected 0", n); end
    endtask

`ifdef CORDIC_SCHED_FIXPRIO_EN
    task automatic test_priority();
        start_run();
        REQ_VALID = 4'b1010;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            n_checks++;
            if (REQ_READY !== 4'b0010) begin n_fail++; $display("FAIL fixprio_grant %0d: got %b expected 0010", k, REQ_READY); end
            @(posedge CLK); #1;
        end
        REQ_VALID = '0; EN = 1'b0;
        repeat (20) @(posedge CLK);
        #1;
    endtask
`else
    task automatic test_priority();
        start_run();
        REQ_VALID = 4'b1010;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            n_checks++;
            if (REQ_READY !== ((k % 2 == 0) ? 4'b0010 : 4'b1000)) begin
                n_fail++; $display("FAIL rr_pair_grant %0d: got %b expected %b", k, REQ_READY, (k % 2 == 0) ? 4'b0010 : 4'b1000);
            end
            @(posedge CLK); #1;
        end
        REQ_VALID = '0; EN = 1'b0;
        repeat (20) @(posedge CLK);
        #1;
    endtask
`endif

    task automatic test_random();
        int bad = 0;
        start_run();
        for (int k = 0; k < 400; k++) begin
            EN = ($urandom_range(0, 9) != 0);
            REQ_VALID = 4'($urandom_range(0, 15));
            REQ_PHASE = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(negedge CLK);
            if ((REQ_READY & (REQ_READY - 4'd1)) != 4'b0 || (REQ_READY & ~REQ_VALID) != 4'b0) bad++;
            @(posedge CLK); #1;
        end
        EN = 1'b1; REQ_VALID = '0;
        repeat (20) @(posedge CLK);
        #1 EN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_checks += 2;
        if (bad != 0) begin n_fail++; $display("FAIL random_onehot: got %0d bad grants expected 0", bad); end
        if (BUSY !== 1'b0) begin n_fail++; $display("FAIL random_final_busy: got %b expected 0", BUSY); end
    endtask

    initial begin
        fork
            scoreboard_loop();
        join_none
        test_reset();
        test_single();
        test_rr_burst();
        test_quadrant();
        test_drain();
        test_rst_mid();
        test_priority();
        test_random();
        @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
